dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported DMEM data memory. Shares DMEM between the core load/store unit (port 0) and the debug/loader port (port 1). Fixed priority to port 0 with a starvation guard for port 1. Routes pipelined read responses back to the issuing port and optionally rejects misaligned accesses.

## Interface
Parameters:
- ADDR_W, 14, DMEM byte-address width
- RD_LAT, 1, DMEM read latency in cycles (DATA_OUT valid RD_LAT cycles after the RDEN edge); range 1..4
- MAX_WAIT, 8, consecutive denied cycles before port 1 takes priority; ≥1

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- Px_REQ  in  1  request, x∈{0,1}
- Px_WE  in  1  1=write, 0=read
- Px_BYTE_SEL  in  2  00 byte, 01 half, 10 word (11 treated as word)
- Px_SIGN  in  1  sign-extend on sub-word read
- Px_ADDR  in  ADDR_W  byte address
- Px_WDATA  in  32  write data
- Px_GNT  out  1  request accepted this cycle (combinational)
- Px_RVALID  out  1  read data valid
- Px_RDATA  out  32  read data
- Px_ERR  out  1  misaligned-access response
- DM_RDEN, DM_WEN  out  1  to DMEM RDEN/WEN
- DM_BYTE_SEL  out  2; DM_SIGN  out  1; DM_ADDR  out  ADDR_W; DM_DATA_IN  out  32  to DMEM
- DM_DATA_OUT  in  32  from DMEM (already extended)

## Operation
- Grant: starve = (wait_cnt == MAX_WAIT). P0_GNT = P0_REQ & ~(starve & P1_REQ). P1_GNT = P1_REQ & (~P0_REQ | starve). At most one grant per cycle.
- Requester holds REQ and all fields stable until GNT; a granted request is consumed on that edge.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle P1_REQ & ~P1_GNT; clears on P1_GNT or ~P1_REQ.
- DM_* mux the granted port’s fields; with no grant, all DM_* = 0. DM_RDEN = gnt & ~WE & ~mis; DM_WEN = gnt & WE & ~mis.
- Response pipeline: RD_LAT-stage shift register of {valid, port, is_read, err}, loaded on every grant. At stage RD_LAT output: Px_RVALID = valid & port==x & is_read; Px_ERR = valid & port==x & err; Px_RDATA = err ? 0 : DM_DATA_OUT (both ports see DM_DATA_OUT, qualified by RVALID).
- Writes complete on the grant edge; no RVALID for writes.
- Back-to-back grants every cycle, any mix of ports; no bubbles.

## Timing
- Reset (RST_N low, async): wait_cnt=0, pipeline cleared; Px_RVALID=Px_ERR=0, Px_RDATA=0. With REQ low, all DM_* and GNT=0.
- Read: GNT in cycle N → RVALID in cycle N+RD_LAT, one cycle wide.
- Simultaneous REQ, no starve: P0 in cycle N, P1 in cycle N+1 if P0 drops.
- Starvation: P1 denied for MAX_WAIT consecutive cycles → granted in the next cycle.
- Reset mid-operation: in-flight reads are dropped; no RVALID/ERR after release.
- Write then read to the same address on consecutive grants returns the new data.

## Configuration
- DMEM_ARB_ALIGN_CHK_EN defined: mis = (half & ADDR[0]) | (word & ADDR[1:0]≠0). A misaligned access is granted, DMEM is not touched, and ERR pulses at N+RD_LAT (with RVALID for reads, RDATA=0).
- Undefined: mis=0; all accesses pass to DMEM; Px_ERR tied 0.

## Structure
- Shared package dmem_pkg: BYTE_SEL encodings (BS_BYTE, BS_HALF, BS_WORD), DMEM request struct {we, byte_sel, sign, addr, wdata}, response tag struct.
- One sub-module: dmem_rsp_pipe (RD_LAT-deep tag shift register with async reset).

## Test plan
- Reset release, no requests → all DM_*, GNT, RVALID, ERR = 0.
- P0 word write 0xdeadbeef @0 → P0_GNT, DM_WEN=1, DM_BYTE_SEL=10 same cycle; P0 word read @0 next → P0_RVALID one cycle later, P0_RDATA=0xdeadbeef.
- Both REQ reads (P0 @4, P1 @8) → P0_GNT cycle N, P1_GNT N+1; RVALID0 at N+1, RVALID1 at N+2, correct data each.
- P0_REQ held continuously, P1_REQ held, MAX_WAIT=8 → P1 denied 8 cycles, granted 9th; wait_cnt returns to 0.
- P1 word read @1: macro on → P1_GNT, DM_RDEN=0, next cycle P1_RVALID=1, P1_ERR=1, P1_RDATA=0; macro off → DM_RDEN=1, DM_ADDR=1, ERR=0.
- P0 read granted, RST_N pulsed low next cycle → no P0_RVALID; outputs at reset values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the DMEM arbiter: byte-select encodings, request and
// response-tag structs, and the alignment helper used when
// DMEM_ARB_ALIGN_CHK_EN is defined.
package dmem_pkg;

   // Access size encodings as seen on BYTE_SEL (11 behaves as a word)
   typedef enum logic [1:0] {
      BS_BYTE     = 2'b00,
      BS_HALF     = 2'b01,
      BS_WORD     = 2'b10,
      BS_WORD_ALT = 2'b11
   } byte_sel_e;

   // Width of the address field carried in a request; the arbiter's ADDR_W
   // must not exceed this
   localparam int DMEM_ADDR_W = 14;

   // One DMEM access as presented by a requester
   typedef struct packed {
      logic                   we;
      logic [1:0]             byte_sel;
      logic                   sign;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [31:0]            wdata;
   } dmem_req_t;

   // Bookkeeping that travels alongside an access until its response is due
   typedef struct packed {
      logic valid;
      logic port;
      logic is_read;
      logic err;
   } rsp_tag_t;

   localparam int RSP_TAG_W = $bits(rsp_tag_t);

   // A half access needs an even address, a word access a multiple of four
   function automatic logic is_misaligned(input logic [1:0] byte_sel,
                                          input logic [1:0] addr_lo);
      case (byte_sel)
         BS_BYTE: return 1'b0;
         BS_HALF: return addr_lo[0];
         default: return (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Response tag delay line: carries {valid, port, is_read, err} for RD_LAT
// cycles so the tag lines up with DMEM read data.
module dmem_rsp_pipe
   import dmem_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [RSP_TAG_W-1:0] tag_in,
   output logic [RSP_TAG_W-1:0] tag_out
);

   logic [RSP_TAG_W-1:0] stage_q [RD_LAT];
   logic [RSP_TAG_W-1:0] stage_d [RD_LAT];

   // Shift every stage down one slot; stage 0 always takes the new tag
   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Tag registers; reset drops any in-flight responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported DMEM. Port 0 (load/store
// unit) has fixed priority; port 1 (debug/loader) is promoted after MAX_WAIT
// consecutive denied cycles. Read responses are routed back to the issuer.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN rejects misaligned accesses
// with an ERR response instead of touching DMEM.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              P0_REQ,
   input  logic              P0_WE,
   input  logic [1:0]        P0_BYTE_SEL,
   input  logic              P0_SIGN,
   input  logic [ADDR_W-1:0] P0_ADDR,
   input  logic [31:0]       P0_WDATA,
   output logic              P0_GNT,
   output logic              P0_RVALID,
   output logic [31:0]       P0_RDATA,
   output logic              P0_ERR,
   input  logic              P1_REQ,
   input  logic              P1_WE,
   input  logic [1:0]        P1_BYTE_SEL,
   input  logic              P1_SIGN,
   input  logic [ADDR_W-1:0] P1_ADDR,
   input  logic [31:0]       P1_WDATA,
   output logic              P1_GNT,
   output logic              P1_RVALID,
   output logic [31:0]       P1_RDATA,
   output logic              P1_ERR,
   output logic              DM_RDEN,
   output logic              DM_WEN,
   output logic [1:0]        DM_BYTE_SEL,
   output logic              DM_SIGN,
   output logic [ADDR_W-1:0] DM_ADDR,
   output logic [31:0]       DM_DATA_IN,
   input  logic [31:0]       DM_DATA_OUT
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                 starve;
   logic                 p0_gnt, p1_gnt, gnt_any, mis;
   dmem_req_t            p0_req, p1_req, req_sel;
   rsp_tag_t             tag_in, tag_out;
   logic [RSP_TAG_W-1:0] tag_in_v, tag_out_v;

   // Grant decision and DMEM request mux; DM_* idle at zero with no grant
   always_comb begin
      starve  = (wait_cnt_q == CNT_W'(MAX_WAIT));
      p0_gnt  = P0_REQ & ~(starve & P1_REQ);
      p1_gnt  = P1_REQ & (~P0_REQ | starve);
      gnt_any = p0_gnt | p1_gnt;

      p0_req = '{we: P0_WE, byte_sel: P0_BYTE_SEL, sign: P0_SIGN,
                 addr: DMEM_ADDR_W'(P0_ADDR), wdata: P0_WDATA};
      p1_req = '{we: P1_WE, byte_sel: P1_BYTE_SEL, sign: P1_SIGN,
                 addr: DMEM_ADDR_W'(P1_ADDR), wdata: P1_WDATA};
      req_sel = p1_gnt ? p1_req : p0_req;

`ifdef DMEM_ARB_ALIGN_CHK_EN
      mis = gnt_any & is_misaligned(req_sel.byte_sel, req_sel.addr[1:0]);
`else
      mis = 1'b0;
`endif

      DM_RDEN     = 1'b0;
      DM_WEN      = 1'b0;
      DM_BYTE_SEL = 2'b00;
      DM_SIGN     = 1'b0;
      DM_ADDR     = '0;
      DM_DATA_IN  = 32'h0;
      if (gnt_any) begin
         DM_RDEN     = ~req_sel.we & ~mis;
         DM_WEN      = req_sel.we & ~mis;
         DM_BYTE_SEL = req_sel.byte_sel;
         DM_SIGN     = req_sel.sign;
         DM_ADDR     = ADDR_W'(req_sel.addr);
         DM_DATA_IN  = req_sel.wdata;
      end

      tag_in = '{valid: gnt_any, port: p1_gnt,
                 is_read: gnt_any & ~req_sel.we, err: mis};
      tag_in_v = tag_in;
   end

   assign P0_GNT = p0_gnt;
   assign P1_GNT = p1_gnt;

   // Count consecutive denied cycles for port 1, saturating at MAX_WAIT
   always_comb begin
      wait_cnt_d = '0;
      if (P1_REQ & ~p1_gnt) begin
         wait_cnt_d = starve ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      end
   end

   // Starvation counter register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   dmem_rsp_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rsp_pipe (
      .clk     (CLK),
      .rst_n   (RST_N),
      .tag_in  (tag_in_v),
      .tag_out (tag_out_v)
   );

   // Route the matured tag and DMEM read data to the issuing port
   always_comb begin
      tag_out   = tag_out_v;
      P0_RVALID = tag_out.valid & ~tag_out.port & tag_out.is_read;
      P1_RVALID = tag_out.valid & tag_out.port & tag_out.is_read;
      P0_RDATA  = (P0_RVALID & ~tag_out.err) ? DM_DATA_OUT : 32'h0;
      P1_RDATA  = (P1_RVALID & ~tag_out.err) ? DM_DATA_OUT : 32'h0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
      P0_ERR    = tag_out.valid & ~tag_out.port & tag_out.err;
      P1_ERR    = tag_out.valid & tag_out.port & tag_out.err;
`else
      P0_ERR    = 1'b0;
      P1_ERR    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural DMEM, shadow memory model and a
// response scoreboard checked every cycle.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 14;
   localparam int RD_LAT   = 1;
   localparam int MAX_WAIT = 8;

   logic              CLK, RST_N;
   logic              P0_REQ, P0_WE, P0_SIGN, P1_REQ, P1_WE, P1_SIGN;
   logic [1:0]        P0_BYTE_SEL, P1_BYTE_SEL;
   logic [ADDR_W-1:0] P0_ADDR, P1_ADDR;
   logic [31:0]       P0_WDATA, P1_WDATA;
   logic              P0_GNT, P0_RVALID, P0_ERR, P1_GNT, P1_RVALID, P1_ERR;
   logic [31:0]       P0_RDATA, P1_RDATA;
   logic              DM_RDEN, DM_WEN, DM_SIGN;
   logic [1:0]        DM_BYTE_SEL;
   logic [ADDR_W-1:0] DM_ADDR;
   logic [31:0]       DM_DATA_IN, DM_DATA_OUT;

   typedef struct {
      int          due;
      logic        port;
      logic        is_read;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [7:0]  dmem   [256];
   logic [7:0]  shadow [256];
   logic [31:0] rd_pipe [RD_LAT];

   logic              snap_wen, snap_rden;
   logic [1:0]        snap_bs;
   logic [ADDR_W-1:0] snap_addr;
   logic [31:0]       snap_din;
   int                snap_wait;

   logic        ev0, ev1, ee0, ee1;
   logic [31:0] ed0, ed1;
   exp_t        me;

   dmem_arbiter #(
      .ADDR_W (ADDR_W), .RD_LAT (RD_LAT), .MAX_WAIT (MAX_WAIT)
   ) dut (
      .CLK (CLK), .RST_N (RST_N),
      .P0_REQ (P0_REQ), .P0_WE (P0_WE), .P0_BYTE_SEL (P0_BYTE_SEL),
      .P0_SIGN (P0_SIGN), .P0_ADDR (P0_ADDR), .P0_WDATA (P0_WDATA),
      .P0_GNT (P0_GNT), .P0_RVALID (P0_RVALID), .P0_RDATA (P0_RDATA),
      .P0_ERR (P0_ERR),
      .P1_REQ (P1_REQ), .P1_WE (P1_WE), .P1_BYTE_SEL (P1_BYTE_SEL),
      .P1_SIGN (P1_SIGN), .P1_ADDR (P1_ADDR), .P1_WDATA (P1_WDATA),
      .P1_GNT (P1_GNT), .P1_RVALID (P1_RVALID), .P1_RDATA (P1_RDATA),
      .P1_ERR (P1_ERR),
      .DM_RDEN (DM_RDEN), .DM_WEN (DM_WEN), .DM_BYTE_SEL (DM_BYTE_SEL),
      .DM_SIGN (DM_SIGN), .DM_ADDR (DM_ADDR), .DM_DATA_IN (DM_DATA_IN),
      .DM_DATA_OUT (DM_DATA_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Sub-word load with optional sign extension, little-endian bytes
   function automatic logic [31:0] load_val(input logic [7:0] b0, b1, b2, b3,
                                            input logic [1:0] bs, input logic sign);
      case (bs)
         2'b00:   return {{24{sign & b0[7]}}, b0};
         2'b01:   return {{16{sign & b1[7]}}, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   function automatic logic mis_f(input logic [1:0] bs, input logic [ADDR_W-1:0] a);
`ifdef DMEM_ARB_ALIGN_CHK_EN
      return (bs == 2'b01 && a[0]) || (bs[1] && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Behavioural single-ported DMEM with RD_LAT read latency
   always @(posedge CLK) begin
      if (DM_WEN) begin
         dmem[DM_ADDR[7:0]] <= DM_DATA_IN[7:0];
         if (DM_BYTE_SEL != 2'b00) dmem[DM_ADDR[7:0] + 8'd1] <= DM_DATA_IN[15:8];
         if (DM_BYTE_SEL[1]) begin
            dmem[DM_ADDR[7:0] + 8'd2] <= DM_DATA_IN[23:16];
            dmem[DM_ADDR[7:0] + 8'd3] <= DM_DATA_IN[31:24];
         end
      end
      rd_pipe[0] <= DM_RDEN ? load_val(dmem[DM_ADDR[7:0]], dmem[DM_ADDR[7:0] + 8'd1],
                                       dmem[DM_ADDR[7:0] + 8'd2], dmem[DM_ADDR[7:0] + 8'd3],
                                       DM_BYTE_SEL, DM_SIGN)
                            : $urandom();
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign DM_DATA_OUT = rd_pipe[RD_LAT-1];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] bs,
                           input logic sign, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
      if (p == 0) begin
         P0_REQ = req; P0_WE = we; P0_BYTE_SEL = bs; P0_SIGN = sign; P0_ADDR = a; P0_WDATA = wd;
      end else begin
         P1_REQ = req; P1_WE = we; P1_BYTE_SEL = bs; P1_SIGN = sign; P1_ADDR = a; P1_WDATA = wd;
      end
   endtask

   // Called in the cycle a grant is seen: snapshot DM_* and queue the response
   task automatic record_grant(input int p);
      logic we, sign;
      logic [1:0] bs;
      logic [ADDR_W-1:0] a;
      logic [31:0] wd;
      logic [7:0] ai;
      exp_t e;
      if (p == 0) begin we = P0_WE; bs = P0_BYTE_SEL; sign = P0_SIGN; a = P0_ADDR; wd = P0_WDATA; end
      else        begin we = P1_WE; bs = P1_BYTE_SEL; sign = P1_SIGN; a = P1_ADDR; wd = P1_WDATA; end
      snap_wen = DM_WEN; snap_rden = DM_RDEN; snap_bs = DM_BYTE_SEL;
      snap_addr = DM_ADDR; snap_din = DM_DATA_IN;
      ai = a[7:0];
      e.due = cyc + RD_LAT;
      e.port = (p == 1);
      e.is_read = !we;
      e.err = mis_f(bs, a);
      e.data = (e.err || we) ? 32'h0 :
               load_val(shadow[ai], shadow[ai + 8'd1], shadow[ai + 8'd2], shadow[ai + 8'd3], bs, sign);
      if (we && !e.err) begin
         shadow[ai] = wd[7:0];
         if (bs != 2'b00) shadow[ai + 8'd1] = wd[15:8];
         if (bs[1]) begin
            shadow[ai + 8'd2] = wd[23:16];
            shadow[ai + 8'd3] = wd[31:24];
         end
      end
      sb.push_back(e);
   endtask

   // Issue one request on a port (entered 1 time unit after a rising edge),
   // hold it until granted, then drop it after the consuming edge
   task automatic applyStimulus(input int p, input logic we, input logic [1:0] bs, input logic sign,
                                input logic [ADDR_W-1:0] a, input logic [31:0] wd);
      int  w;
      bit  got;
      w = 0;
      got = 0;
      set_port(p, 1'b1, we, bs, sign, a, wd);
      while (!got && w < 40) begin
         #1;
         if ((p == 0) ? P0_GNT : P1_GNT) begin
            record_grant(p);
            got = 1;
         end else begin
            @(posedge CLK);
            #1;
            w++;
         end
      end
      if (!got) checkOutput("gnt_timeout", 32'd0, 32'd1);
      snap_wait = w;
      @(posedge CLK);
      #1;
      set_port(p, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
   endtask

   // Every cycle: retire due scoreboard entries and compare response outputs
   always @(posedge CLK) begin
      #4;
      ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0; ed0 = 0; ed1 = 0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         me = sb.pop_front();
         if (me.port) begin ev1 = me.is_read; ee1 = me.err; ed1 = me.data; end
         else         begin ev0 = me.is_read; ee0 = me.err; ed0 = me.data; end
      end
      checkOutput("p0_rvalid", P0_RVALID, ev0);
      checkOutput("p1_rvalid", P1_RVALID, ev1);
      checkOutput("p0_err", P0_ERR, ee0);
      checkOutput("p1_err", P1_ERR, ee1);
      if (ev0) checkOutput("p0_rdata", P0_RDATA, ed0);
      if (ev1) checkOutput("p1_rdata", P1_RDATA, ed1);
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST_N = 1'b0;
      set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
      set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
      for (int i = 0; i < 256; i++) begin
         dmem[i] = 8'h00;
         shadow[i] = 8'h00;
      end
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;

      // Idle after reset release
      #1;
      checkOutput("idle_rden", DM_RDEN, 0);
      checkOutput("idle_wen", DM_WEN, 0);
      checkOutput("idle_addr", DM_ADDR, 0);
      checkOutput("idle_din", DM_DATA_IN, 0);
      checkOutput("idle_bsel", DM_BYTE_SEL, 0);
      checkOutput("idle_sign", DM_SIGN, 0);
      checkOutput("idle_gnt0", P0_GNT, 0);
      checkOutput("idle_gnt1", P1_GNT, 0);
      checkOutput("idle_rdata0", P0_RDATA, 0);
      checkOutput("idle_rdata1", P1_RDATA, 0);
      @(posedge CLK);
      #1;

      // Word write then read back on consecutive grants
      applyStimulus(0, 1'b1, 2'b10, 1'b0, 14'd0, 32'hdeadbeef);
      checkOutput("wr_wen", snap_wen, 1);
      checkOutput("wr_rden", snap_rden, 0);
      checkOutput("wr_bsel", snap_bs, 2'b10);
      checkOutput("wr_din", snap_din, 32'hdeadbeef);
      checkOutput("wr_wait", snap_wait, 0);
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 14'd0, 32'h0);
      checkOutput("rd_rden", snap_rden, 1);

      // Sub-word accesses across both ports
      applyStimulus(1, 1'b1, 2'b01, 1'b0, 14'd2, 32'h12348001);
      applyStimulus(0, 1'b0, 2'b01, 1'b1, 14'd2, 32'h0);
      applyStimulus(0, 1'b0, 2'b01, 1'b0, 14'd2, 32'h0);
      applyStimulus(1, 1'b0, 2'b00, 1'b0, 14'd3, 32'h0);
      applyStimulus(1, 1'b0, 2'b00, 1'b1, 14'd3, 32'h0);
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 14'd0, 32'h0);
      applyStimulus(1, 1'b1, 2'b10, 1'b0, 14'd4, 32'h11111111);
      applyStimulus(0, 1'b1, 2'b11, 1'b0, 14'd8, 32'h22222222);

      // Simultaneous requests: port 0 first, port 1 the cycle after
      set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 14'd4, 32'h0);
      set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 14'd8, 32'h0);
      #1;
      checkOutput("both_gnt0", P0_GNT, 1);
      checkOutput("both_gnt1", P1_GNT, 0);
      if (P0_GNT) record_grant(0);
      @(posedge CLK);
      #1 P0_REQ = 1'b0;
      #1;
      checkOutput("both2_gnt0", P0_GNT, 0);
      checkOutput("both2_gnt1", P1_GNT, 1);
      if (P1_GNT) record_grant(1);
      @(posedge CLK);
      #1 P1_REQ = 1'b0;

      // Starvation guard, two rounds to show the counter restarts from zero
      set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 14'd0, 32'h0);
      set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 14'd8, 32'h0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            #1;
            if (i <= MAX_WAIT) begin
               checkOutput($sformatf("starve_r%0d_c%0d_gnt1", r, i), P1_GNT, 0);
               checkOutput($sformatf("starve_r%0d_c%0d_gnt0", r, i), P0_GNT, 1);
            end else begin
               checkOutput($sformatf("starve_r%0d_win_gnt1", r), P1_GNT, 1);
               checkOutput($sformatf("starve_r%0d_win_gnt0", r), P0_GNT, 0);
            end
            if (P0_GNT) record_grant(0);
            if (P1_GNT) record_grant(1);
            @(posedge CLK);
            #1;
         end
      end
      P0_REQ = 1'b0;
      P1_REQ = 1'b0;

      // Misaligned accesses
      applyStimulus(1, 1'b0, 2'b10, 1'b0, 14'd1, 32'h0);
      checkOutput("mis_rden", snap_rden, !mis_f(2'b10, 14'd1));
      checkOutput("mis_addr", snap_addr, 14'd1);
      applyStimulus(0, 1'b1, 2'b01, 1'b0, 14'd5, 32'h0000ffff);
      checkOutput("mis_wen", snap_wen, !mis_f(2'b01, 14'd5));
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 14'd4, 32'h0);

      // Reset while a read is in flight
      set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 14'd0, 32'h0);
      #1;
      checkOutput("rst_gnt0", P0_GNT, 1);
      @(posedge CLK);
      #1;
      RST_N = 1'b0;
      P0_REQ = 1'b0;
      sb.delete();
      #1;
      checkOutput("rst_rvalid0", P0_RVALID, 0);
      checkOutput("rst_rdata0", P0_RDATA, 0);
      checkOutput("rst_err0", P0_ERR, 0);
      checkOutput("rst_rden", DM_RDEN, 0);
      checkOutput("rst_gnt0_low", P0_GNT, 0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      repeat (RD_LAT + 1) @(posedge CLK);
      #1;
      applyStimulus(1, 1'b0, 2'b10, 1'b0, 14'd4, 32'h0);

      repeat (RD_LAT + 2) @(posedge CLK);
      #6;
      checkOutput("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
